block_spi_master: RTL and testbench

SPI master that sends one address byte and one data byte per frame over a 4-wire bus, MSB first, SPI mode 0. It is the initiating end of the address/data register-write protocol our SPI slave accepts. It lets one FPGA design, or a test harness, drive duty-cycle and control registers in another. It also captures the MISO byte returned during the data phase.

---
 rtl/block_spi_pkg.sv | 18 +
 rtl/block_spi_sck_gen.sv | 38 +++
 rtl/block_spi_master.sv | 125 ++++++++++++
 tb/tb_block_spi_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_spi_pkg.sv
// Shared SPI definitions for the address/data register-write link.
// Used by both the master and the slave ends.
package block_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS  = 8;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/block_spi_sck_gen.sv
// SCK divider: H-cycle phases, one-cycle rise/fall ticks.
// Cleared whenever the enable is low.
module block_spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic phase
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] cnt;
  logic          wrap;

  assign wrap      = en && (cnt == DW'(CLK_DIV - 1));
  assign rise_tick = wrap && !phase;
  assign fall_tick = wrap && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/block_spi_master.sv
// SPI mode-0 master: one address byte plus one data byte per frame,
// capturing the MISO byte returned during the data phase.
module block_spi_master
  import block_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] address_in,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       SPI_SCK,
  output logic       SPI_CS,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  spi_state_e state, state_d;

  logic [FRAME_BITS-1:0] sh;
  logic [BYTE_BITS-1:0]  rx;
  logic [4:0]            bit_cnt;
  logic [GW-1:0]         gap_cnt;

  logic sck_en;
  logic rise_tick;
  logic fall_tick;
  logic phase;
  logic last_bit;
  logic gap_end;

  assign sck_en   = (state == SHIFT) || (state == HOLD);
  assign last_bit = bit_cnt == 5'(FRAME_BITS - 1);
  assign gap_end  = gap_cnt == GW'(CS_GAP - 1);
  assign SPI_MOSI = sh[FRAME_BITS-1];

  block_spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sck_en),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: if (fall_tick && last_bit) state_d = HOLD;
      HOLD:  if (rise_tick) state_d = GAP;
      GAP:   if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The HOLD phase reuses the divider: its first rise tick ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      data_out <= '0;
      SPI_CS   <= 1'b1;
      SPI_SCK  <= CPOL;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh      <= {address_in, data_in};
            SPI_CS  <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          SPI_SCK <= rise_tick | (phase & ~fall_tick);
          if (rise_tick && bit_cnt >= 5'(BYTE_BITS))
            rx <= {rx[BYTE_BITS-2:0], SPI_MISO};
          if (fall_tick) begin
            sh      <= {sh[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= last_bit ? '0 : bit_cnt + 5'd1;
          end
        end
        HOLD: begin
          SPI_SCK <= CPOL;
          if (rise_tick) begin
            SPI_CS   <= 1'b1;
            done     <= 1'b1;
            data_out <= rx;
            gap_cnt  <= '0;
          end
        end
        GAP: begin
          if (gap_end) begin
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_spi_master.sv
// Scoreboard bench for block_spi_master: default and fast-divider
// instances behind a shared slave model and done-driven monitor.
module tb_block_spi_master;

  typedef struct {
    int         done_cyc;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rx;
    int         h;
    int         g;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic miso;

  logic cs0, sck0, mosi0, busy0, done0;
  logic cs1, sck1, mosi1, busy1, done1;
  logic [7:0] dout0, dout1;

  logic cs_m, sck_m, mosi_m, busy_m, done_m;
  logic [7:0] dout_m;

  logic [15:0] slave_word = 16'h0000;
  logic [15:0] stx = 16'h0000;
  logic [15:0] srx = 16'h0000;
  int sbits = 0;

  int cs_low = 0;
  int hi_run = 0;
  int busy_due = -1;
  int g_last = 0;
  bit have_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cs_m   = sel ? cs1 : cs0;
  assign sck_m  = sel ? sck1 : sck0;
  assign mosi_m = sel ? mosi1 : mosi0;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign dout_m = sel ? dout1 : dout0;

  block_spi_master u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & ~sel),
    .address_in(addr),
    .data_in   (data),
    .busy      (busy0),
    .done      (done0),
    .data_out  (dout0),
    .SPI_SCK   (sck0),
    .SPI_CS    (cs0),
    .SPI_MOSI  (mosi0),
    .SPI_MISO  (miso)
  );

  block_spi_master #(
    .CLK_DIV(2),
    .CS_GAP (1)
  ) u_dut_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start & sel),
    .address_in(addr),
    .data_in   (data),
    .busy      (busy1),
    .done      (done1),
    .data_out  (dout1),
    .SPI_SCK   (sck1),
    .SPI_CS    (cs1),
    .SPI_MOSI  (mosi1),
    .SPI_MISO  (miso)
  );

  // Slave model: mode 0, drives MISO while SCK is low.
  assign miso = stx[15];

  always @(negedge cs_m) begin
    stx   <= slave_word;
    srx   <= 16'h0000;
    sbits <= 0;
  end

  always @(negedge sck_m)
    if (!cs_m) stx <= {stx[14:0], 1'b0};

  always @(posedge sck_m)
    if (!cs_m) begin
      srx   <= {srx[14:0], mosi_m};
      sbits <= sbits + 1;
    end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int hc();
    return sel ? 2 : 4;
  endfunction

  function automatic int gc();
    return sel ? 1 : 2;
  endfunction

  // Monitor: consumes one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_low    = 0;
      hi_run    = 0;
      busy_due  = -1;
      have_done = 1'b0;
    end else begin
      if (!cs_m) begin
        cs_low++;
        if (have_done) begin
          chk("cs_gap_min", 32'(hi_run >= g_last + 1), 1);
          have_done = 1'b0;
        end
        hi_run = 0;
      end else begin
        hi_run++;
      end
      if (busy_due == cyc) begin
        chk("busy_drop", 32'(busy_m), 0);
        busy_due = -1;
      end
      if (done_m) begin
        n_done++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_done: got 1 want 0 (cyc %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("done_cyc", cyc, mon_e.done_cyc);
          chk("data_out", 32'(dout_m), 32'(mon_e.rx));
          chk("slave_word", 32'(srx), 32'({mon_e.a, mon_e.d}));
          chk("slave_bits", sbits, 16);
          chk("cs_low_len", cs_low, 33 * mon_e.h);
          chk("busy_at_done", 32'(busy_m), 1);
          busy_due  = cyc + mon_e.g;
          g_last    = mon_e.g;
          have_done = 1'b1;
        end
        cs_low = 0;
        hi_run = 1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_m !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("cyc_timeout", 1, 0);
  endtask

  task automatic push(input int acc,
                      input logic [7:0] a, d, md);
    exp_t e;
    e.done_cyc = acc + 33 * hc();
    e.a  = a;
    e.d  = d;
    e.rx = md;
    e.h  = hc();
    e.g  = gc();
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] a, d, ma, md,
                      input bit do_push, output int acc);
    wait_idle();
    slave_word = {ma, md};
    addr  = a;
    data  = d;
    start = 1'b1;
    acc   = cyc + 1;
    if (do_push) push(acc, a, d, md);
    @(negedge clk);
    start = 1'b0;
  endtask

  localparam int P = 33 * 4 + 2 + 1;

  initial begin
    int acc;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs0), 1);
    chk("rst_sck", 32'(sck0), 0);
    chk("rst_mosi", 32'(mosi0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_cs_fast", 32'(cs1), 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    send(8'h03, 8'hA5, 8'h00, 8'h5A, 1'b1, acc);
    send(8'h81, 8'h7E, 8'hFF, 8'h3C, 1'b1, acc);

    send(8'h01, 8'h11, 8'hFF, 8'hC3, 1'b1, acc);
    wait_cyc(acc + 40);
    addr  = 8'h02;
    data  = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("ignored_busy", 32'(busy_m), 0);
    chk("ignored_queue", q.size(), 0);

    wait_idle();
    slave_word = 16'h6699;
    addr  = 8'h10;
    data  = 8'h20;
    start = 1'b1;
    acc   = cyc + 1;
    push(acc, 8'h10, 8'h20, 8'h99);
    push(acc + P, 8'h11, 8'h21, 8'h99);
    push(acc + 2 * P, 8'h12, 8'h22, 8'h99);
    wait_cyc(acc);
    addr = 8'h11;
    data = 8'h21;
    wait_cyc(acc + P);
    addr = 8'h12;
    data = 8'h22;
    wait_cyc(acc + 2 * P);
    start = 1'b0;

    send(8'h55, 8'hAA, 8'h12, 8'h34, 1'b0, acc);
    wait_cyc(acc + 60);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs0), 1);
    chk("midrst_sck", 32'(sck0), 0);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_done", 32'(done0), 0);
    chk("midrst_dout", 32'(dout0), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (150) @(negedge clk);
    send(8'h3C, 8'hC3, 8'hAA, 8'h55, 1'b1, acc);

    wait_idle();
    sel = 1'b1;
    @(negedge clk);
    send(8'hA7, 8'h5C, 8'h0F, 8'hF0, 1'b1, acc);
    send(8'h00, 8'hFF, 8'h96, 8'h69, 1'b1, acc);
    wait_idle();

    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("done_count", n_done, 9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
